// File: rtl/wm_loader_if.sv
// rtl/wm_loader_if.sv - host weight stream and unit weight-memory write bus
//
// Groups the host-side valid/ready word stream and the write port broadcast to
// the convolution-unit weight memories.
//   host_data / host_valid / host_ready : host -> loader word stream
//   riscv_data                         : write data, broadcast to all units
//   wm_enable_write                    : one-hot write strobe, bit u = unit u
//   wm_address                         : write address shared by all units
// Modports: master = host/unit-array side, slave = loader side.
interface wm_loader_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUMBER_OF_UNITS = 3,
    parameter int ADDRESS_SIZE_WM = 12
);
    logic [DATA_WIDTH-1:0]      host_data;
    logic                       host_valid;
    logic                       host_ready;
    logic [DATA_WIDTH-1:0]      riscv_data;
    logic [NUMBER_OF_UNITS-1:0] wm_enable_write;
    logic [ADDRESS_SIZE_WM-1:0] wm_address;

    modport master (
        output host_data,
        output host_valid,
        input  host_ready,
        input  riscv_data,
        input  wm_enable_write,
        input  wm_address
    );

    modport slave (
        input  host_data,
        input  host_valid,
        output host_ready,
        output riscv_data,
        output wm_enable_write,
        output wm_address
    );
endinterface

// File: rtl/wm_loader.sv
// rtl/wm_loader.sv - weight-memory loader for the convolution-unit array
//
// Takes a filter-major stream of weights from the host and writes filter f into
// unit (f mod NUMBER_OF_UNITS), slot (f / NUMBER_OF_UNITS) of the weight memory.
// A handshake in cycle N produces the registered write strobe, address and data
// in cycle N+1.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : one-cycle request to begin a full load, honoured only in IDLE
//   bus       : wm_loader_if.slave (host stream in, weight-memory write port out)
//   busy      : high while in LOAD
//   done      : one-cycle pulse coincident with the final write strobe
//   checksum  : XOR of all words of the last/current load
//
// Optional feature macro: WM_LOADER_CHECKSUM_EN (checksum register). When it is
// not defined, checksum is tied to zero.
module wm_loader #(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_DEPTH         = 15,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 30,
    parameter int NUMBER_OF_UNITS   = 3,
    parameter int FILTER_WORDS      = KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH,
    parameter int CEIL_FILTERS      = (NUMBER_OF_FILTERS + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int ADDRESS_SIZE_WM   = $clog2(FILTER_WORDS * CEIL_FILTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    wm_loader_if.slave            bus,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int WORD_W = (FILTER_WORDS > 1) ? $clog2(FILTER_WORDS) : 1;
    localparam int UNIT_W = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;
    localparam int SLOT_W = (CEIL_FILTERS > 1) ? $clog2(CEIL_FILTERS) : 1;

    localparam logic [WORD_W-1:0]          WORD_MAX  = WORD_W'(FILTER_WORDS - 1);
    localparam logic [UNIT_W-1:0]          UNIT_MAX  = UNIT_W'(NUMBER_OF_UNITS - 1);
    // Owner of the very last filter; with an uneven split this is not the top unit.
    localparam logic [UNIT_W-1:0]          LAST_UNIT = UNIT_W'((NUMBER_OF_FILTERS - 1) % NUMBER_OF_UNITS);
    localparam logic [SLOT_W-1:0]          LAST_SLOT = SLOT_W'((NUMBER_OF_FILTERS - 1) / NUMBER_OF_UNITS);
    localparam logic [ADDRESS_SIZE_WM-1:0] FW_ADDR   = ADDRESS_SIZE_WM'(FILTER_WORDS);
    localparam logic [ADDRESS_SIZE_WM-1:0] ADDR_ONE  = ADDRESS_SIZE_WM'(1);
    localparam logic [NUMBER_OF_UNITS-1:0] UNIT0_HOT = NUMBER_OF_UNITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                     state;
    logic [WORD_W-1:0]          word_idx;
    logic [UNIT_W-1:0]          unit_idx;
    logic [SLOT_W-1:0]          slot_idx;
    // run_addr always equals slot_idx*FILTER_WORDS + word_idx; slot_base holds
    // slot_idx*FILTER_WORDS so a unit change can rewind without a multiplier.
    logic [ADDRESS_SIZE_WM-1:0] run_addr;
    logic [ADDRESS_SIZE_WM-1:0] slot_base;

    logic handshake;
    logic last_word;

    assign handshake = (state == S_LOAD) && bus.host_valid && bus.host_ready;
    assign last_word = (slot_idx == LAST_SLOT) && (unit_idx == LAST_UNIT) && (word_idx == WORD_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            word_idx            <= '0;
            unit_idx            <= '0;
            slot_idx            <= '0;
            run_addr            <= '0;
            slot_base           <= '0;
            bus.host_ready      <= 1'b0;
            bus.riscv_data      <= '0;
            bus.wm_enable_write <= '0;
            bus.wm_address      <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            // Strobe and done are single-cycle pulses unless re-armed below.
            bus.wm_enable_write <= '0;
            done                <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_LOAD;
                        word_idx       <= '0;
                        unit_idx       <= '0;
                        slot_idx       <= '0;
                        run_addr       <= '0;
                        slot_base      <= '0;
                        bus.host_ready <= 1'b1;
                        busy           <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (handshake) begin
                        bus.wm_enable_write <= UNIT0_HOT << unit_idx;
                        bus.wm_address      <= run_addr;
                        bus.riscv_data      <= bus.host_data;
                        if (last_word) begin
                            // Final strobe, done and busy fall all land in FLUSH.
                            state          <= S_FLUSH;
                            bus.host_ready <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                        end else if (word_idx == WORD_MAX) begin
                            word_idx <= '0;
                            if (unit_idx == UNIT_MAX) begin
                                // Next slot starts right after the current filter.
                                unit_idx  <= '0;
                                slot_idx  <= slot_idx + SLOT_W'(1);
                                slot_base <= slot_base + FW_ADDR;
                                run_addr  <= run_addr + ADDR_ONE;
                            end else begin
                                unit_idx <= unit_idx + UNIT_W'(1);
                                run_addr <= slot_base;
                            end
                        end else begin
                            word_idx <= word_idx + WORD_W'(1);
                            run_addr <= run_addr + ADDR_ONE;
                        end
                    end
                end

                S_FLUSH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state          <= S_IDLE;
                    bus.host_ready <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

`ifdef WM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // Holds after done until the next accepted start or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum_q <= '0;
        end else if (handshake) begin
            checksum_q <= checksum_q ^ bus.host_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_wm_loader.sv
// tb/tb_wm_loader.sv - scoreboard bench for wm_loader (default and uneven-split builds)
module tb_wm_loader;

    localparam int DW     = 32;
    localparam int NU     = 3;
    localparam int FW     = 375;
    localparam int NF     = 30;
    localparam int AW     = 12;
    localparam int NWORDS = NF * FW;

    localparam int S_NU     = 3;
    localparam int S_FW     = 2;
    localparam int S_AW     = 2;
    localparam int S_NWORDS = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_m = 1'b0;
    logic start_s = 1'b0;
    logic busy_m, done_m, busy_s, done_s;
    logic [DW-1:0] cs_m, cs_s;

    always #5 clk = ~clk;

    wm_loader_if #(.DATA_WIDTH(DW), .NUMBER_OF_UNITS(NU), .ADDRESS_SIZE_WM(AW)) bus_m ();
    wm_loader_if #(.DATA_WIDTH(DW), .NUMBER_OF_UNITS(S_NU), .ADDRESS_SIZE_WM(S_AW)) bus_s ();

    wm_loader dut_m (
        .clk      (clk),
        .reset    (reset),
        .start    (start_m),
        .bus      (bus_m.slave),
        .busy     (busy_m),
        .done     (done_m),
        .checksum (cs_m)
    );

    wm_loader #(
        .DATA_WIDTH        (DW),
        .IFM_DEPTH         (2),
        .KERNAL_SIZE       (1),
        .NUMBER_OF_FILTERS (4),
        .NUMBER_OF_UNITS   (S_NU)
    ) dut_s (
        .clk      (clk),
        .reset    (reset),
        .start    (start_s),
        .bus      (bus_s.slave),
        .busy     (busy_s),
        .done     (done_s),
        .checksum (cs_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes_m = 0;
    logic [31:0] cs_model = 32'h0;

    typedef struct {
        logic [61:0] exp;
        int          hs;
        int          g;
    } sb_t;

    sb_t q_m[$];
    sb_t q_s[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected strobe packed as {latency, one-hot unit, address, data, done, busy}.
    function automatic logic [61:0] model(input int g, input int fw, input int nu,
                                          input int nwords, input logic [31:0] d);
        int f;
        int w;
        logic [3:0]  en;
        logic [15:0] a;
        logic        last;
        f    = g / fw;
        w    = g % fw;
        en   = 4'(1) << (f % nu);
        a    = 16'((f / nu) * fw + w);
        last = (g == nwords - 1);
        return {8'd1, en, a, d, last, ~last};
    endfunction

    function automatic logic [31:0] cs_expect();
`ifdef WM_LOADER_CHECKSUM_EN
        return cs_model;
`else
        return 32'h0;
`endif
    endfunction

    // Main-instance monitor.
    always @(negedge clk) begin
        sb_t it;
        if (reset) begin
            if (bus_m.wm_enable_write != '0) begin
                strobes_m++;
                if (q_m.size() == 0) begin
                    check_val("m_unexpected_strobe", 64'(bus_m.wm_enable_write), 64'd0);
                end else begin
                    it = q_m.pop_front();
                    check_val($sformatf("m_strobe_g%0d", it.g),
                              {2'b0, 8'(cyc - it.hs), 4'(bus_m.wm_enable_write), 16'(bus_m.wm_address),
                               bus_m.riscv_data, done_m, busy_m},
                              {2'b0, it.exp});
                    if (done_m)
                        check_val("m_checksum_at_done", 64'(cs_m), 64'(cs_expect()));
                end
            end else if (done_m) begin
                check_val("m_done_without_strobe", 64'(done_m), 64'd0);
            end
        end
    end

    // Uneven-split instance monitor.
    always @(negedge clk) begin
        sb_t it;
        if (reset) begin
            if (bus_s.wm_enable_write != '0) begin
                if (q_s.size() == 0) begin
                    check_val("s_unexpected_strobe", 64'(bus_s.wm_enable_write), 64'd0);
                end else begin
                    it = q_s.pop_front();
                    check_val($sformatf("s_strobe_g%0d", it.g),
                              {2'b0, 8'(cyc - it.hs), 4'(bus_s.wm_enable_write), 16'(bus_s.wm_address),
                               bus_s.riscv_data, done_s, busy_s},
                              {2'b0, it.exp});
                end
            end else if (done_s) begin
                check_val("s_done_without_strobe", 64'(done_s), 64'd0);
            end
        end
    end

    task automatic start_main();
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        cs_model = 32'h0;
    endtask

    // Present one word; returns #1 after the accepting edge with host_valid low.
    task automatic send_m(input int g, input logic [31:0] d);
        bit taken;
        taken = 1'b0;
        bus_m.host_data  = d;
        bus_m.host_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clk);
            if (bus_m.host_ready) begin
                q_m.push_back('{model(g, FW, NU, NWORDS, d), cyc, g});
                cs_model = cs_model ^ d;
                taken = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!taken) check_val("m_ready_timeout", 64'(taken), 64'd1);
        bus_m.host_valid = 1'b0;
    endtask

    task automatic send_s(input int g, input logic [31:0] d);
        bit taken;
        taken = 1'b0;
        bus_s.host_data  = d;
        bus_s.host_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clk);
            if (bus_s.host_ready) begin
                q_s.push_back('{model(g, S_FW, S_NU, S_NWORDS, d), cyc, g});
                taken = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!taken) check_val("s_ready_timeout", 64'(taken), 64'd1);
        bus_s.host_valid = 1'b0;
    endtask

    task automatic idle_m(input int n);
        bus_m.host_valid = 1'b0;
        bus_m.host_data  = $urandom;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_m(input string pfx);
        check_val({pfx, "_ready"}, 64'(bus_m.host_ready), 64'd0);
        check_val({pfx, "_en"},    64'(bus_m.wm_enable_write), 64'd0);
        check_val({pfx, "_addr"},  64'(bus_m.wm_address), 64'd0);
        check_val({pfx, "_data"},  64'(bus_m.riscv_data), 64'd0);
        check_val({pfx, "_busy"},  64'(busy_m), 64'd0);
        check_val({pfx, "_done"},  64'(done_m), 64'd0);
        check_val({pfx, "_cs"},    64'(cs_m), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    // Valid held high while the loader is not in LOAD must never be taken.
    task automatic valid_while_not_ready(input string pfx);
        bus_m.host_valid = 1'b1;
        bus_m.host_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check_val({pfx, "_ready_low"}, 64'(bus_m.host_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus_m.host_valid = 1'b0;
    endtask

    task automatic full_load(input int mode);
        logic [31:0] d;
        start_main();
        for (int g = 0; g < NWORDS; g++) begin
            case (mode)
                0:       d = 32'(g);
                1:       d = 32'hA5A5_A5A5;
                default: d = (g == 5000) ? 32'h0000_0001 : 32'hA5A5_A5A5;
            endcase
            send_m(g, d);
            if (mode == 0 && $urandom_range(15) == 0) idle_m($urandom_range(2, 1));
        end
        valid_while_not_ready($sformatf("m_after_done%0d", mode));
        check_val("m_busy_after_done", 64'(busy_m), 64'd0);
        check_val("m_queue_drained", 64'(q_m.size()), 64'd0);
        check_val("m_checksum_hold", 64'(cs_m), 64'(cs_expect()));
    endtask

    initial begin
        int s0;
        bus_m.host_valid = 1'b0;
        bus_m.host_data  = '0;
        bus_s.host_valid = 1'b0;
        bus_s.host_data  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_zero_m("m_reset");
        @(posedge clk); #1 reset = 1'b1;

        // IDLE refuses host_valid.
        valid_while_not_ready("m_idle");

        // Backpressure gaps: valid 1,0,0,1 gives two strobes at addresses 0 and 1.
        start_main();
        s0 = strobes_m;
        send_m(0, $urandom);
        idle_m(2);
        send_m(1, $urandom);
        idle_m(3);
        check_val("m_gap_strobes", 64'(strobes_m - s0), 64'd2);
        check_val("m_gap_queue", 64'(q_m.size()), 64'd0);
        pulse_reset();

        // Uneven split: 4 filters over 3 units, 2 words per filter.
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int g = 0; g < S_NWORDS; g++) send_s(g, 32'h100 + 32'(g));
        repeat (3) @(posedge clk);
        #1;
        check_val("s_queue_drained", 64'(q_s.size()), 64'd0);
        check_val("s_busy_after_done", 64'(busy_s), 64'd0);
        check_val("s_ready_after_done", 64'(bus_s.host_ready), 64'd0);

        // Full load, index data with random gaps.
        full_load(0);

        // Reset mid-load after 100 words, with the word-99 strobe in flight.
        start_main();
        for (int g = 0; g < 100; g++) send_m(g, $urandom);
        bus_m.host_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_zero_m("m_midreset");
        q_m.delete();
        @(posedge clk); #1 reset = 1'b1;
        valid_while_not_ready("m_post_reset");
        start_main();
        for (int g = 0; g < 4; g++) send_m(g, 32'h5000 + 32'(g));
        idle_m(2);
        check_val("m_restart_queue", 64'(q_m.size()), 64'd0);
        pulse_reset();

        // Checksum loads.
        full_load(1);
        full_load(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
